// File: rtl/lcd_cmd_scheduler.sv
// Shares one 12-bit LCD command bus between NREQ command generators.
// Requester 0 owns the bus until boot_done. After that, arbitration is round-robin,
// and a grant stays with its owner while that owner keeps presenting words.
// Wait opcodes run as local delays. Other legal opcodes go to the driver over valid/ready.
module lcd_cmd_scheduler #(
   parameter int unsigned NREQ      = 3,
   parameter int unsigned WAIT1_CYC = 50000,
   parameter int unsigned WAIT2_CYC = 2000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [12*NREQ-1:0] req_data,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_rdy,
   input  logic              boot_done,
   output logic [11:0]       lcd_data,
   output logic              lcd_valid,
   input  logic              lcd_ready,
   output logic [NREQ-1:0]   grant,
   output logic              busy,
   output logic              err
);

   localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned MaxW = (WAIT1_CYC > WAIT2_CYC) ? WAIT1_CYC : WAIT2_CYC;
   localparam int unsigned CntW = $clog2(MaxW + 1);

   typedef enum logic [2:0] {StIdle, StIssue, StWait, StAck, StCheck} state_t;

   state_t            state;
   state_t            disp_state;
   logic [PtrW-1:0]   rr_ptr;
   logic [PtrW-1:0]   g_idx;
   logic [PtrW-1:0]   pick_idx;
   logic [PtrW-1:0]   cand;
   logic [PtrW-1:0]   src_idx;
   logic              pick_found;
   logic              do_dispatch;
   logic [CntW-1:0]   cnt;
   logic [CntW-1:0]   disp_cnt;
   logic [11:0]       src_word;
   logic [NREQ-1:0]   src_oh;
   logic [NREQ-1:0]   elig;
   logic [11:0]       words [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_words
      assign words[i] = req_data[12*i +: 12];
   end

   // Before boot completes only the loader may use the bus.
   assign elig = boot_done ? {NREQ{1'b1}} : {{(NREQ-1){1'b0}}, 1'b1};
   assign busy = (state != StIdle);

   // Round-robin pick, scanning upward from the slot after the last owner.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         cand = PtrW'((32'(rr_ptr) + k) % NREQ);
         if (!pick_found && req_valid[cand] && elig[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   // Decode the word being dispatched: a fresh pick from IDLE, or the owner's next word from CHECK.
   always_comb begin
      src_idx    = (state == StCheck) ? g_idx : pick_idx;
      src_word   = words[src_idx];
      src_oh     = NREQ'(1) << src_idx;
      disp_state = StAck;
      disp_cnt   = '0;
      case (src_word[11:8])
         4'h0, 4'h1, 4'h2, 4'h3: disp_state = StIssue;
         4'h4: begin
            disp_state = StWait;
            disp_cnt   = CntW'(WAIT2_CYC - 1);
         end
         4'hF: begin
            disp_state = StWait;
            disp_cnt   = CntW'(WAIT1_CYC - 1);
         end
         default: disp_state = StAck;
      endcase
      do_dispatch = ((state == StIdle) && pick_found) ||
                    ((state == StCheck) && req_valid[g_idx] && (boot_done || (g_idx == '0)));
   end

   // Scheduler FSM with registered bus, ack and grant outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= StIdle;
         lcd_valid <= 1'b0;
         lcd_data  <= '0;
         req_rdy   <= '0;
         grant     <= '0;
         err       <= 1'b0;
         rr_ptr    <= PtrW'(NREQ - 1);
         g_idx     <= '0;
         cnt       <= '0;
      end else if (do_dispatch) begin
         state <= disp_state;
         g_idx <= src_idx;
         grant <= src_oh;
         case (disp_state)
            StIssue: begin
               lcd_data  <= src_word;
               lcd_valid <= 1'b1;
            end
            StWait:  cnt <= disp_cnt;
            default: begin
               // Illegal opcode: acknowledge it without forwarding it.
               req_rdy <= src_oh;
               err     <= 1'b1;
            end
         endcase
      end else begin
         case (state)
            StIssue: begin
               if (lcd_ready) begin
                  lcd_valid <= 1'b0;
                  req_rdy   <= grant;
                  state     <= StAck;
               end
            end
            StWait: begin
               if (cnt == '0) begin
                  req_rdy <= grant;
                  state   <= StAck;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            StAck: begin
               req_rdy <= '0;
               state   <= StCheck;
            end
            StCheck: begin
               rr_ptr <= g_idx;
               grant  <= '0;
               state  <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_cmd_scheduler.sv
// Scoreboard bench for lcd_cmd_scheduler: requester queues feed the DUT.
// Expected bus words are queued as they are offered and compared against captured transfers.
module tb_lcd_cmd_scheduler;

   localparam int unsigned NREQ = 3;
   localparam int unsigned W1   = 8;
   localparam int unsigned W2   = 5;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [12*NREQ-1:0] req_data;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_rdy;
   logic              boot_done = 1'b0;
   logic [11:0]       lcd_data;
   logic              lcd_valid;
   logic              lcd_ready = 1'b1;
   logic [NREQ-1:0]   grant;
   logic              busy;
   logic              err;

   lcd_cmd_scheduler #(.NREQ(NREQ), .WAIT1_CYC(W1), .WAIT2_CYC(W2)) dut (
      .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid), .req_rdy(req_rdy),
      .boot_done(boot_done), .lcd_data(lcd_data), .lcd_valid(lcd_valid),
      .lcd_ready(lcd_ready), .grant(grant), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   logic [11:0] rq [3][$];
   logic [11:0] exp_q[$];
   logic [2:0]  expg_q[$];
   logic [11:0] obs_q[$];
   logic [2:0]  obsg_q[$];
   int          obsc_q[$];
   int          rdy0_cyc_q[$];
   int          rdy_cnt [3];
   int          wait_vio = 0;
   logic [11:0] feed_tmp;

   // Requester models: present the queue head, drop it once acknowledged.
   initial begin
      req_valid = '0;
      req_data  = '0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            if (req_rdy[i] && rq[i].size() > 0) feed_tmp = rq[i].pop_front();
            req_valid[i] = (rq[i].size() > 0);
            req_data[i*12 +: 12] = (rq[i].size() > 0) ? rq[i][0] : 12'h000;
         end
      end
   end

   // Capture bus transfers and ack pulses away from the active edge.
   initial begin
      for (int i = 0; i < 3; i++) rdy_cnt[i] = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (lcd_valid && lcd_ready) begin
               obs_q.push_back(lcd_data);
               obsg_q.push_back(grant);
               obsc_q.push_back(cyc);
            end
            if (lcd_valid && (lcd_data[11:8] == 4'h4 || lcd_data[11:8] == 4'hF)) wait_vio++;
            for (int i = 0; i < 3; i++) if (req_rdy[i]) rdy_cnt[i]++;
            if (req_rdy[0]) rdy0_cyc_q.push_back(cyc);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic clear_all();
      for (int i = 0; i < 3; i++) begin
         rq[i].delete();
         rdy_cnt[i] = 0;
      end
      exp_q.delete(); expg_q.delete();
      obs_q.delete(); obsg_q.delete(); obsc_q.delete();
      rdy0_cyc_q.delete();
      wait_vio = 0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 rst = 1'b1;
      clear_all();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic offer(input int r, input logic [11:0] w, input bit fwd);
      rq[r].push_back(w);
      if (fwd) begin
         exp_q.push_back(w);
         expg_q.push_back(3'(1 << r));
      end
   endtask

   task automatic wait_obs(input int n, input int budget, output bit ok);
      int c = 0;
      while (obs_q.size() < n && c < budget) begin
         @(posedge clk);
         c++;
      end
      ok = (obs_q.size() >= n);
   endtask

   task automatic pop_pair(output logic [11:0] ew, output logic [2:0] eg,
                           output logic [11:0] ow, output logic [2:0] og, output int oc);
      ew = exp_q.pop_front(); eg = expg_q.pop_front();
      ow = obs_q.pop_front(); og = obsg_q.pop_front(); oc = obsc_q.pop_front();
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_cmp++; if (lcd_valid !== 1'b0) begin n_err++; $display("FAIL reset_lcd_valid: got %b want 0", lcd_valid); end
      n_cmp++; if (lcd_data !== 12'h000) begin n_err++; $display("FAIL reset_lcd_data: got %h want 000", lcd_data); end
      n_cmp++; if (req_rdy !== 3'b000) begin n_err++; $display("FAIL reset_req_rdy: got %b want 000", req_rdy); end
      n_cmp++; if (grant !== 3'b000) begin n_err++; $display("FAIL reset_grant: got %b want 000", grant); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err); end
   endtask

   task automatic test_boot_lock();
      logic [11:0] ew, ow; logic [2:0] eg, og; int oc; bit ok;
      boot_done = 1'b0;
      lcd_ready = 1'b1;
      offer(0, 12'h200, 1'b1);
      for (int k = 0; k < 64; k++) offer(0, 12'h100 + 12'(k), 1'b1);
      rq[1].push_back(12'h1EE);
      wait_obs(65, 400, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL boot_count: got %0d want 65", obs_q.size()); end
      for (int k = 0; k < 65; k++) begin
         if (obs_q.size() == 0 || exp_q.size() == 0) break;
         pop_pair(ew, eg, ow, og, oc);
         n_cmp++;
         if (ow !== ew || og !== eg) begin
            n_err++; $display("FAIL boot_word[%0d]: got %h g%b want %h g%b", k, ow, og, ew, eg);
         end
      end
      repeat (5) @(posedge clk);
      n_cmp++; if (rdy_cnt[1] !== 0) begin n_err++; $display("FAIL boot_rdy1: got %0d want 0", rdy_cnt[1]); end
      n_cmp++; if (obs_q.size() !== 0) begin n_err++; $display("FAIL boot_leak: got %0d extra want 0", obs_q.size()); end
      // Releasing the boot lock lets requester 1 through.
      boot_done = 1'b1;
      exp_q.push_back(12'h1EE); expg_q.push_back(3'b010);
      wait_obs(1, 20, ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL boot_release: got none want 1ee"); end
      else begin
         pop_pair(ew, eg, ow, og, oc);
         if (ow !== ew || og !== eg) begin
            n_err++; $display("FAIL boot_release: got %h g%b want %h g%b", ow, og, ew, eg);
         end
      end
   endtask

   task automatic test_round_robin();
      logic [11:0] ew, ow; logic [2:0] eg, og; int oc; bit ok;
      do_reset();
      boot_done = 1'b1;
      offer(0, 12'h148, 1'b1);
      offer(1, 12'h149, 1'b1);
      offer(2, 12'h14A, 1'b1);
      wait_obs(3, 40, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL rr_count: got %0d want 3", obs_q.size()); end
      repeat (4) @(posedge clk);
      // rr_ptr now 2: requester 0 must beat requester 1.
      #1;
      offer(1, 12'h150, 1'b0);
      offer(0, 12'h151, 1'b1);
      exp_q.push_back(12'h150); expg_q.push_back(3'b010);
      wait_obs(5, 40, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL rr_count2: got %0d want 5", obs_q.size()); end
      for (int k = 0; k < 5; k++) begin
         if (obs_q.size() == 0 || exp_q.size() == 0) break;
         pop_pair(ew, eg, ow, og, oc);
         n_cmp++;
         if (ow !== ew || og !== eg) begin
            n_err++; $display("FAIL rr_word[%0d]: got %h g%b want %h g%b", k, ow, og, ew, eg);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [11:0] ew, ow; logic [2:0] eg, og; int oc; int prev; bit ok;
      repeat (3) @(posedge clk);
      #1;
      offer(1, 12'h380, 1'b1);
      offer(1, 12'h141, 1'b1);
      offer(1, 12'h142, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      offer(2, 12'h155, 1'b1);
      wait_obs(4, 60, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL burst_count: got %0d want 4", obs_q.size()); end
      prev = 0;
      for (int k = 0; k < 4; k++) begin
         if (obs_q.size() == 0 || exp_q.size() == 0) break;
         pop_pair(ew, eg, ow, og, oc);
         n_cmp++;
         if (ow !== ew || og !== eg) begin
            n_err++; $display("FAIL burst_word[%0d]: got %h g%b want %h g%b", k, ow, og, ew, eg);
         end
         if (k == 1 || k == 2) begin
            n_cmp++;
            if (oc - prev !== 3) begin
               n_err++; $display("FAIL burst_spacing[%0d]: got %0d cycles want 3", k, oc - prev);
            end
         end
         prev = oc;
      end
   endtask

   task automatic test_backpressure_wait();
      logic [11:0] ew, ow; logic [2:0] eg, og; int oc; int stable; bit seen; bit ok;
      repeat (3) @(posedge clk);
      #1;
      rdy0_cyc_q.delete();
      wait_vio  = 0;
      lcd_ready = 1'b0;
      offer(0, 12'h101, 1'b1);
      offer(0, 12'h400, 1'b0);
      offer(0, 12'hF00, 1'b0);
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         seen = lcd_valid;
      end
      stable = (seen && lcd_data === 12'h101) ? 1 : 0;
      repeat (9) begin
         @(negedge clk);
         if (lcd_valid === 1'b1 && lcd_data === 12'h101) stable++;
      end
      n_cmp++; if (stable !== 10) begin n_err++; $display("FAIL bp_stable: got %0d cycles want 10", stable); end
      n_cmp++; if (obs_q.size() !== 0) begin n_err++; $display("FAIL bp_early: got %0d transfers want 0", obs_q.size()); end
      @(posedge clk);
      #1 lcd_ready = 1'b1;
      wait_obs(1, 10, ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL bp_word: got none want 101"); end
      else begin
         pop_pair(ew, eg, ow, og, oc);
         if (ow !== ew || og !== eg) begin
            n_err++; $display("FAIL bp_word: got %h g%b want %h g%b", ow, og, ew, eg);
         end
      end
      for (int c = 0; c < 60 && rdy0_cyc_q.size() < 3; c++) @(posedge clk);
      n_cmp++;
      if (rdy0_cyc_q.size() < 3) begin
         n_err++; $display("FAIL wait_acks: got %0d want 3", rdy0_cyc_q.size());
      end else begin
         if (rdy0_cyc_q[1] - rdy0_cyc_q[0] !== int'(W2) + 2) begin
            n_err++; $display("FAIL wait2_len: got %0d want %0d", rdy0_cyc_q[1] - rdy0_cyc_q[0], W2 + 2);
         end
         n_cmp++;
         if (rdy0_cyc_q[2] - rdy0_cyc_q[1] !== int'(W1) + 2) begin
            n_err++; $display("FAIL wait1_len: got %0d want %0d", rdy0_cyc_q[2] - rdy0_cyc_q[1], W1 + 2);
         end
      end
      n_cmp++; if (wait_vio !== 0) begin n_err++; $display("FAIL wait_on_bus: got %0d want 0", wait_vio); end
      n_cmp++; if (obs_q.size() !== 0) begin n_err++; $display("FAIL wait_forwarded: got %0d want 0", obs_q.size()); end
   endtask

   task automatic test_illegal();
      logic [11:0] ew, ow; logic [2:0] eg, og; int oc; int r1; bit ok;
      repeat (3) @(posedge clk);
      #1;
      r1 = rdy_cnt[1];
      offer(1, 12'h7AA, 1'b0);
      repeat (10) @(posedge clk);
      n_cmp++; if (rdy_cnt[1] - r1 !== 1) begin n_err++; $display("FAIL illegal_ack: got %0d want 1", rdy_cnt[1] - r1); end
      n_cmp++; if (obs_q.size() !== 0) begin n_err++; $display("FAIL illegal_fwd: got %0d want 0", obs_q.size()); end
      n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL illegal_err: got %b want 1", err); end
      #1;
      offer(2, 12'h131, 1'b1);
      wait_obs(1, 20, ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL illegal_next: got none want 131"); end
      else begin
         pop_pair(ew, eg, ow, og, oc);
         if (ow !== ew || og !== eg) begin
            n_err++; $display("FAIL illegal_next: got %h g%b want %h g%b", ow, og, ew, eg);
         end
      end
      n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b want 1", err); end
   endtask

   task automatic test_async_reset();
      logic [11:0] ew, ow; logic [2:0] eg, og; int oc; bit seen; bit ok;
      repeat (3) @(posedge clk);
      #1;
      lcd_ready = 1'b0;
      rq[2].push_back(12'h102);
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         seen = lcd_valid;
      end
      n_cmp++; if (!seen) begin n_err++; $display("FAIL ar_issue: got lcd_valid 0 want 1"); end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if (lcd_valid !== 1'b0 || grant !== 3'b000 || busy !== 1'b0 || req_rdy !== 3'b000) begin
         n_err++;
         $display("FAIL ar_outputs: got v%b g%b b%b r%b want v0 g000 b0 r000", lcd_valid, grant, busy, req_rdy);
      end
      n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL ar_err: got %b want 0", err); end
      clear_all();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      lcd_ready = 1'b1;
      offer(1, 12'h111, 1'b0);
      offer(0, 12'h110, 1'b1);
      exp_q.push_back(12'h111); expg_q.push_back(3'b010);
      wait_obs(2, 30, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL ar_count: got %0d want 2", obs_q.size()); end
      for (int k = 0; k < 2; k++) begin
         if (obs_q.size() == 0 || exp_q.size() == 0) break;
         pop_pair(ew, eg, ow, og, oc);
         n_cmp++;
         if (ow !== ew || og !== eg) begin
            n_err++; $display("FAIL ar_word[%0d]: got %h g%b want %h g%b", k, ow, og, ew, eg);
         end
      end
   endtask

   initial begin
      test_reset();
      test_boot_lock();
      test_round_robin();
      test_back_to_back();
      test_backpressure_wait();
      test_illegal();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/lcd_cmd_scheduler.md
Name: lcd_cmd_scheduler

Overview:
- Shares the single 12-bit LCD command bus ({opcode[11:8], payload[7:0]}) between NREQ command generators, e.g. the CGRAM loader and the text/display writers.
- Requester 0 (the CGRAM loader) has exclusive access until boot_done; after that, access is round-robin with sticky bursts.
- Wait opcodes are executed locally as timed delays; all other legal opcodes go to the LCD driver over a valid/ready handshake.
- Each consumed word is acknowledged to its requester with a one-cycle req_rdy pulse, so the requester advances its sequence on the posedge of that pulse.

Parameters:
- NREQ, 3, number of requesters (2..8); index 0 is the boot-time loader.
- WAIT1_CYC, 50000, cycles executed for opcode 4'hF (wait1), >=1.
- WAIT2_CYC, 2000, cycles executed for opcode 4'h4 (wait2), >=1.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- req_data  input  12*NREQ  command word of requester i at bits [12i+11:12i]
- req_valid  input  NREQ  requester i holds a word
- req_rdy  output  NREQ  one-cycle pulse: word of requester i consumed
- boot_done  input  1  loader finished (EN_out of the CGRAM loader); level, sampled every cycle
- lcd_data  output  12  command word to the LCD driver
- lcd_valid  output  1  lcd_data valid
- lcd_ready  input  1  driver accepts the word when lcd_valid && lcd_ready
- grant  output  NREQ  one-hot current owner, 0 when idle
- busy  output  1  state != IDLE
- err  output  1  sticky: illegal opcode seen

Behaviour:
- Legal opcodes:
  - 4'h0 clear, 4'h1 write, 4'h2 setcg, 4'h3 setad: forwarded to the driver.
  - 4'h4 wait2, 4'hF wait1: executed locally, never forwarded.
  - Any other opcode is illegal: acknowledged, not forwarded, err set to 1 until reset.
- Reset (async, immediate): state=IDLE; lcd_valid=0; lcd_data=0; req_rdy=0; grant=0; busy=0; err=0; rr_ptr=NREQ-1.
- Eligibility: while boot_done=0, only requester 0 is eligible. Once boot_done=1, all requesters are eligible.
- IDLE:
  - If no eligible req_valid, stay in IDLE.
  - Otherwise pick the first eligible valid requester scanning rr_ptr+1, rr_ptr+2, ... modulo NREQ. Set grant to it and latch its word.
  - Next state: ISSUE for a forwarded opcode, WAIT for a wait opcode, ACK for an illegal opcode.
- ISSUE:
  - lcd_valid=1 and lcd_data holds the latched word, stable until accepted.
  - When lcd_ready=1, the word transfers that cycle; go to ACK. lcd_valid falls the next cycle.
- WAIT:
  - Counter loads N-1 (N = WAIT1_CYC or WAIT2_CYC) and decrements each cycle.
  - At 0, go to ACK. WAIT occupies exactly N cycles.
- ACK: req_rdy[g]=1 for exactly one cycle; go to CHECK.
- CHECK (gives the requester one cycle to present its next word):
  - If req_valid[g]=1 and g is still eligible, latch the new word and dispatch as in IDLE without re-arbitration. The grant is sticky, so setcg/setad and the writes that follow are never interleaved.
  - Otherwise set rr_ptr=g, grant=0, go to IDLE.
- Latency:
  - req_valid to lcd_valid: 1 cycle from IDLE, 1 cycle from CHECK.
  - Accepted word to req_rdy: 1 cycle.
  - Sustained throughput with lcd_ready held high: one word per 3 cycles.
- Simultaneous events:
  - A requester dropping req_valid during ISSUE or WAIT has no effect on the latched word; the word is still completed and acked.
  - boot_done falling after it has risen affects eligibility only at the next IDLE or CHECK decision.
- Only lcd_data and err hold state across words.

Test Plan:
- Boot lock: boot_done=0, req 0 and req 1 valid. Req 0 streams 65 words (0x200, 0x100..), lcd_ready=1. Required: exactly 65 lcd transfers in order, all from req 0, req_rdy[1] never pulses.
- Round-robin: boot_done=1, req 0/1/2 each present one word (0x148, 0x149, 0x14A), drop valid after ack. Required: lcd order 0x148, 0x149, 0x14A; then with rr_ptr=2 a new req 0/1 request grants 0 first.
- Sticky burst: req 1 sends 0x380,0x141,0x142 back-to-back while req 2 is valid. Required: three req 1 words contiguous before any req 2 word; transfers 3 cycles apart with lcd_ready=1.
- Backpressure and wait: lcd_ready=0 for 10 cycles on word 0x101, then a wait2 (0x400) with WAIT2_CYC=5. Required: lcd_data stable at 0x101 with lcd_valid=1 for 10 cycles; wait2 is never on lcd_valid and takes 5 cycles before its req_rdy.
- Illegal opcode: req 1 sends 0x7AA. Required: req_rdy[1] pulses, lcd_valid stays 0, err=1 and stays 1 through later traffic.
- Async reset in ISSUE: assert rst mid-cycle while lcd_valid=1. Required: lcd_valid, grant, busy and req_rdy go to 0 immediately; after release, arbitration restarts with req 0 highest.
